mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Sequencing controller for the multicycle MIPS32 datapath (shared instruction/data memory, one ALU).
//  Moore FSM: fetch, decode and instruction-specific steps; drives datapath muxes, write enables and ALU op.
//  Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi, j, jal. Waits on a memory-ready handshake.
//  Sits inside the mips core beside the datapath, replacing the single-cycle main/ALU decoders.
// PARAMETERS
//  RA_REG     5'd31  register written by jal (via regdst=10)
// PORTS
//  clk         in   1  clock; all state updates on rising edge
//  reset       in   1  asynchronous, active-high; forces state to FETCH
//  op          in   6  instr[31:26] from instruction register
//  funct       in   6  instr[5:0] from instruction register
//  zero        in   1  ALU zero flag
//  mem_ready   in   1  shared memory completes access this cycle
//  pcen        out  1  PC register enable = pcwrite | (branch & zero)
//  memwrite    out  1  memory write strobe
//  irwrite     out  1  instruction register load
//  regwrite    out  1  register file write enable
//  iord        out  1  memory address: 0=PC, 1=ALUOut
//  alusrca     out  1  ALU A: 0=PC, 1=rs register
//  alusrcb     out  2  ALU B: 00=rt reg, 01=4, 10=signext imm, 11=signext imm<<2
//  pcsrc       out  2  next PC: 00=ALU result, 01=ALUOut, 10=jump target
//  regdst      out  2  write reg: 00=rt, 01=rd, 10=RA_REG
//  memtoreg    out  2  write data: 00=ALUOut, 01=mem data reg, 10=PC
//  alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  illegal_op  out  1  one-cycle pulse in DECODE on unsupported op
//  state       out  4  current state (debug/bench visibility)
// BEHAVIOUR
//  States (4-bit): FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 RTYPEEX=6 RTYPEWB=7
//   BEQEX=8 ADDIEX=9 ADDIWB=10 JEX=11 JALEX=12. Codes 13-15 -> next state FETCH, all outputs 0.
//  Outputs are combinational from state (plus mem_ready/zero/funct as noted); unlisted outputs are 0.
//  FETCH: iord=0 alusrcb=01 add pcsrc=00; irwrite=pcwrite=mem_ready; stay until mem_ready=1, then DECODE.
//  DECODE: alusrcb=11 add (branch target into ALUOut). Next by op: 100011/101011->MEMADR,
//   000000->RTYPEEX, 000100->BEQEX, 001000->ADDIEX, 000010->JEX, 000011->JALEX;
//   other op -> FETCH with illegal_op=1 (instruction retired as nop).
//  MEMADR: alusrca=1 alusrcb=10 add; op=lw->MEMRD, sw->MEMWR.
//  MEMRD: iord=1; wait for mem_ready, then MEMWB. MEMWB: regdst=00 memtoreg=01 regwrite=1 -> FETCH.
//  MEMWR: iord=1, memwrite=1 held until mem_ready=1, then FETCH (write completes that cycle).
//  RTYPEEX: alusrca=1 alusrcb=00, alucontrol from funct: 100000 add, 100010 sub, 100100 and,
//   100101 or, 101010 slt; unknown funct -> add. -> RTYPEWB.
//  RTYPEWB: regdst=01 memtoreg=00 regwrite=1; alucontrol held as RTYPEEX. -> FETCH.
//  BEQEX: alusrca=1 alusrcb=00 sub, branch=1 pcsrc=01; pcen=zero. -> FETCH.
//  ADDIEX: alusrca=1 alusrcb=10 add -> ADDIWB. ADDIWB: regdst=00 memtoreg=00 regwrite=1 -> FETCH.
//  JEX: pcsrc=10 pcwrite=1 -> FETCH.
//  JALEX: pcsrc=10 pcwrite=1, regwrite=1 regdst=10 memtoreg=10 (writes PC+4, PC updated same edge) -> FETCH.
//  Latency with mem_ready tied 1: beq/j/jal 3, R-type/addi/sw 4, lw 5 cycles; each mem wait adds 1.
//  Reset: state=FETCH asynchronously; while reset high outputs show FETCH values (alusrcb=01,
//   alucontrol=010, irwrite/pcen=mem_ready gated by reset -> 0); reset mid-instruction abandons it,
//   no regwrite/memwrite after reset asserts.
//  pcen asserted at most once per instruction; memwrite only in MEMWR; regwrite only in writeback states.
// TESTING
//  reset pulse mid-RTYPEEX -> state=0 immediately, regwrite never asserted, irwrite=0 during reset.
//  mem_ready=1, op=000000 funct=100010 -> states 0,1,6,7,0; alucontrol=110 in 6/7; regwrite in 7 only.
//  op=100011, mem_ready low 2 cycles in FETCH and MEMRD -> 0,0,0,1,2,3,3,3,4,0; irwrite one cycle.
//  op=000100 with zero=1 -> pcen=1 pcsrc=01 in state 8; repeat zero=0 -> pcen=0, back to FETCH.
//  op=000011 -> state 12: pcen=1 pcsrc=10 regwrite=1 regdst=10 memtoreg=10, then FETCH.
//  op=111111 -> DECODE illegal_op=1 for one cycle, next state 0, no regwrite/memwrite.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Moore sequencing controller for the multicycle MIPS32 datapath (one shared
//   instruction/data memory, one ALU). Steps each instruction through FETCH,
//   DECODE and instruction-specific states. It drives the datapath muxes, the
//   write enables and the ALU operation. Memory accesses stall on mem_ready.
//   Supported: lw, sw, R-type (add/sub/and/or/slt), beq, addi, j, jal.
//
// Ports
//   clk, reset          rising-edge clock; async active-high reset -> FETCH
//   op, funct           instr[31:26] / instr[5:0] from the instruction register
//   zero                ALU zero flag (qualifies beq)
//   mem_ready           shared memory completes its access this cycle
//   pcen                PC enable = pcwrite | (branch & zero)
//   memwrite, irwrite   memory write strobe, instruction register load
//   regwrite            register file write enable
//   iord                memory address select: 0=PC, 1=ALUOut
//   alusrca / alusrcb   ALU A: 0=PC 1=rs; ALU B: 00=rt 01=4 10=imm 11=imm<<2
//   pcsrc               next PC: 00=ALU result 01=ALUOut 10=jump target
//   regdst              write reg: 00=rt 01=rd 10=RA_REG
//   memtoreg            write data: 00=ALUOut 01=mem data 10=PC
//   alucontrol          010 add, 110 sub, 000 and, 001 or, 111 slt
//   illegal_op          one-cycle pulse in DECODE for an unsupported op
//   state               current state code (debug)
module mips_multicycle_ctrl #(
    parameter logic [4:0] RA_REG = 5'd31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] regdst,
    output logic [1:0] memtoreg,
    output logic [2:0] alucontrol,
    output logic       illegal_op,
    output logic [3:0] state
);

    // The controller only emits regdst=10; RA_REG is consumed by the
    // datapath. Linking through $zero would silently drop the return address.
    if (RA_REG == 5'd0) begin : g_ra_reg_check
        $error("RA_REG must not be register 0");
    end

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        JALEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t state_q, state_d;
    logic   pcwrite, branch;

    // Unknown funct codes fall back to add.
    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_alu = ALU_ADD;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = FETCH;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        iord       = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        regdst     = 2'b00;
        memtoreg   = 2'b00;
        alucontrol = 3'b000;
        illegal_op = 1'b0;

        case (state_q)
            FETCH: begin
                // Reset forces this state asynchronously. Gating with reset
                // keeps the IR and PC from loading while reset is held.
                alusrcb    = 2'b01;
                alucontrol = ALU_ADD;
                irwrite    = mem_ready & ~reset;
                pcwrite    = mem_ready & ~reset;
                state_d    = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // Precompute the branch target into ALUOut while decoding.
                alusrcb    = 2'b11;
                alucontrol = ALU_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    OP_JAL:       state_d = JALEX;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                if (op == OP_SW)      state_d = MEMWR;
                else if (op == OP_LW) state_d = MEMRD;
                else                  state_d = FETCH;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                memtoreg = 2'b01;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                state_d  = mem_ready ? FETCH : MEMWR;
            end
            RTYPEEX: begin
                alusrca    = 1'b1;
                alucontrol = funct_alu(funct);
                state_d    = RTYPEWB;
            end
            RTYPEWB: begin
                regdst     = 2'b01;
                regwrite   = 1'b1;
                alucontrol = funct_alu(funct);
            end
            BEQEX: begin
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                branch     = 1'b1;
                pcsrc      = 2'b01;
            end
            ADDIEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = ALU_ADD;
                state_d    = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            JALEX: begin
                // Link register gets PC (already PC+4) on the same edge the
                // PC takes the jump target.
                pcsrc    = 2'b10;
                pcwrite  = 1'b1;
                regwrite = 1'b1;
                regdst   = 2'b10;
                memtoreg = 2'b10;
            end
            default: state_d = FETCH;
        endcase

        pcen = pcwrite | (branch & zero);
    end

    assign state = state_q;

endmodule
